// File: rtl/div_iter_pkg.sv
// Shared state encodings, handshake levels and helpers for the iterative divider.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [5:0] DivLastStep = 6'd31;

  // Two's-complement magnitude; 0x80000000 maps to itself and is read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: trial-subtract the divisor from the partial remainder.
module div_step
  import div_iter_pkg::*;
(
  input  logic [64:0] work,
  input  logic [31:0] divisor,
  output logic [64:0] next_work
);

  logic [32:0] trial;

  always_comb begin
    trial     = work[64:32] - {1'b0, divisor};
    next_work = {work[63:0], 1'b0};
    if (!trial[32]) begin
      next_work = {trial[31:0], work[31:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider answering the EX start/ready stall handshake.
module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state;
  logic [64:0] work;
  logic [64:0] next_work;
  logic [31:0] divisor;
  logic [5:0]  count;
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  div_step u_step (
    .work      (work),
    .divisor   (divisor),
    .next_work (next_work)
  );

  // Remainder lives in work[64:33], quotient in work[31:0] after the last step.
  always_comb begin
    quo_fix = neg_if(work[31:0], neg_quo);
    rem_fix = neg_if(work[64:33], neg_rem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      work     <= '0;
      divisor  <= '0;
      count    <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= DivByZero;
            end else begin
              state   <= DivOn;
              // Dividend sits one bit up so the first trial already sees its MSB.
              work    <= {32'd0, abs32(opdata1_i, signed_div_i), 1'b0};
              divisor <= abs32(opdata2_i, signed_div_i);
              neg_quo <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem <= signed_div_i && opdata1_i[31];
              count   <= '0;
            end
          end
        end

        DivByZero: begin
          work    <= '0;
          neg_quo <= 1'b0;
          neg_rem <= 1'b0;
          state   <= DivEnd;
        end

        DivOn: begin
          // Abort wins even on the final step: nothing is delivered.
          if (annul_i || start_i == DivStop) begin
            state <= DivFree;
          end else begin
            work  <= next_work;
            count <= count + 6'd1;
            if (count == DivLastStep) begin
              state <= DivEnd;
            end
          end
        end

        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else begin
            ready_o  <= DivResultReady;
            result_o <= {rem_fix, quo_fix};
          end
        end

        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed plus random checks of div_iter: latency, results, abort, reset and hold behaviour.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  div_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit integer division, truncating toward zero.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives a request and returns right after the accepting edge.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
  endtask

  // Waits (bounded) for ready, checks latency and result, holds, then drops start.
  task automatic await_result(input string tag, input int lat, input int hold, input logic poke_annul);
    int cyc;
    logic [63:0] e;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (ready_o !== 1'b1 && cyc < 60);
    check($sformatf("%s_lat", tag), 64'(cyc), 64'(lat));
    e = exp_q.pop_front();
    check($sformatf("%s_res", tag), result_o, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      annul_i = poke_annul;
      opdata1_i = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("%s_hold%0d", tag, i), {ready_o, result_o[62:0]}, {1'b1, e[62:0]});
    end
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("%s_drop", tag), {63'd0, ready_o} | result_o, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv);
    exp_q.push_back(expv);
    launch(s, a, b);
    await_result(tag, (b == 32'd0) ? 2 : 33, 0, 1'b0);
  endtask

  // Starts op1, aborts it after n_steps ON steps, then issues op2 on the next edge.
  task automatic abort_restart(input string tag, input logic use_annul, input int n_steps,
                               input logic [31:0] a2, input logic [31:0] b2);
    launch(1'b0, 32'd5000, 32'd9);
    repeat (n_steps) @(posedge clk);
    @(negedge clk);
    if (use_annul) annul_i = 1'b1;
    else start_i = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("%s_abort", tag), {63'd0, ready_o} | result_o, 64'd0);
    exp_q.push_back(model(1'b0, a2, b2));
    @(negedge clk);
    annul_i   = 1'b0;
    start_i   = 1'b1;
    opdata1_i = a2;
    opdata2_i = b2;
    @(posedge clk);
    await_result(tag, 33, 0, 1'b0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_op("u_div0", 1'b0, 32'd5, 32'd0, 64'd0);
    run_op("s_div0", 1'b1, 32'hFFFFFFF9, 32'd0, 64'd0);
    run_op("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
    run_op("u_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    run_op("u_small_big", 1'b0, 32'd3, 32'h80000000, 64'h00000003_00000000);

    abort_restart("annul10", 1'b1, 10, 32'd1234567, 32'd89);
    abort_restart("drop20", 1'b0, 20, 32'hDEADBEEF, 32'd1000);

    // Reset mid-operation: outputs stay 0, then the block works normally.
    launch(1'b0, 32'd777, 32'd5);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_step15", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    run_op("after_rst", 1'b0, 32'd777, 32'd5, 64'h00000002_0000009B);

    // Held result stays put for 5 cycles despite annul and operand churn.
    exp_q.push_back(64'h00000001_0000014D);
    launch(1'b0, 32'd1000, 32'd3);
    await_result("hold5", 33, 5, 1'b1);

    // Reset while the result is being presented.
    exp_q.push_back(model(1'b1, 32'hFFFFF000, 32'd7));
    launch(1'b1, 32'hFFFFF000, 32'd7);
    repeat (33) @(posedge clk);
    #1;
    check("rst_end_ready", {63'd0, ready_o}, 64'd1);
    check("rst_end_res", result_o, exp_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_end", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_op($sformatf("rand%0d", i), s, a, b, model(s, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
